// File: rtl/audio_path_ctrl.sv
// -----------------------------------------------------------------------------
// audio_path_ctrl
//
// Sequencing controller between the SPI receiver, the effect stage and the DAC
// driver. Debounces the mode button, switches between the original and effect
// paths only between samples, waits for the effect stage (with a timeout that
// falls back to the original sample), hands one sample per frame to the DAC
// driver and counts overruns.
//
// Ports:
//   clk_25mhz       in   system clock, all logic on the rising edge
//   reset           in   synchronous, active-high reset
//   mode_btn        in   raw asynchronous mode push-button, active-high
//   data_ready      in   1-cycle pulse, new sample on original_audio
//   original_audio  in   [15:0] receiver sample, valid with data_ready
//   modified_audio  in   [15:0] effect output, valid with process_status
//   process_status  in   effect stage done for the current sample
//   dac_busy        in   DAC driver shifting a frame, no start accepted
//   dac_sample      out  [15:0] sample presented to the DAC driver
//   dac_start       out  1-cycle strobe, dac_sample valid in the same cycle
//   mode_active     out  0 = original path, 1 = effect path
//   eff_timeout     out  sticky, set when the effect stage timed out
//   drop_count      out  [7:0] saturating count of dropped samples
// -----------------------------------------------------------------------------
module audio_path_ctrl #(
    parameter int clock_max   = 25_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int EFF_TIMEOUT = 512
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        data_ready,
    input  logic [15:0] original_audio,
    input  logic [15:0] modified_audio,
    input  logic        process_status,
    input  logic        dac_busy,
    output logic [15:0] dac_sample,
    output logic        dac_start,
    output logic        mode_active,
    output logic        eff_timeout,
    output logic [7:0]  drop_count
);

    localparam int DB_CYCLES = clock_max / 1000 * DEBOUNCE_MS;
    localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TO_W      = (EFF_TIMEOUT > 1) ? $clog2(EFF_TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(EFF_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EFF,
        WAIT_DAC
    } state_t;

    // ---------------- button path ----------------
    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;
    logic            btn_s;
    logic            toggle_set;

    assign btn_s = sync_q[1];
    // Debounced level rises this cycle: the only event that requests a toggle.
    assign toggle_set = btn_s && !db_level_q && (db_cnt_q == DB_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of order.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sync_q     <= 2'b00;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], mode_btn};
            // Count only while the synchronised input disagrees with the
            // debounced level; any return to agreement restarts the window.
            if (btn_s == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_q   <= '0;
                db_level_q <= btn_s;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- sequencing FSM ----------------
    state_t          state_q;
    logic            toggle_req_q;
    logic            mode_active_q;
    logic            mode_eff;
    logic [TO_W-1:0] eff_cnt_q;
    logic [15:0]     shadow_q;
    logic [15:0]     held_q;
    logic [15:0]     dac_sample_q;
    logic            dac_start_q;
    logic            eff_timeout_q;
    logic [7:0]      drop_count_q;

    // A pending toggle is applied in IDLE in the same cycle a sample may be
    // accepted, so that sample already follows the new mode.
    assign mode_eff = mode_active_q ^ toggle_req_q;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q       <= IDLE;
            toggle_req_q  <= 1'b0;
            mode_active_q <= 1'b0;
            eff_cnt_q     <= '0;
            shadow_q      <= '0;
            held_q        <= '0;
            dac_sample_q  <= '0;
            dac_start_q   <= 1'b0;
            eff_timeout_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            dac_start_q <= 1'b0;

            // Pending request survives until IDLE; a repeated press while
            // pending just keeps it set.
            toggle_req_q <= toggle_set || (toggle_req_q && (state_q != IDLE));

            if (data_ready && (state_q != IDLE) && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (toggle_req_q) begin
                        mode_active_q <= ~mode_active_q;
                    end
                    if (data_ready) begin
                        shadow_q <= original_audio;
                        if (mode_eff) begin
                            eff_cnt_q <= '0;
                            state_q   <= WAIT_EFF;
                        end else begin
                            held_q  <= original_audio;
                            state_q <= WAIT_DAC;
                        end
                    end
                end
                WAIT_EFF: begin
                    if (process_status) begin
                        held_q  <= modified_audio;
                        state_q <= WAIT_DAC;
                    end else if (eff_cnt_q == TO_LAST) begin
                        // Effect stage too slow: play the dry sample instead.
                        held_q        <= shadow_q;
                        eff_timeout_q <= 1'b1;
                        state_q       <= WAIT_DAC;
                    end else begin
                        eff_cnt_q <= eff_cnt_q + 1'b1;
                    end
                end
                WAIT_DAC: begin
                    if (!dac_busy) begin
                        dac_sample_q <= held_q;
                        dac_start_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dac_sample  = dac_sample_q;
    assign dac_start   = dac_start_q;
    assign mode_active = mode_active_q;
    assign eff_timeout = eff_timeout_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_audio_path_ctrl.sv
// -----------------------------------------------------------------------------
// tb_audio_path_ctrl
//
// Self-checking bench for audio_path_ctrl: directed scenarios for reset,
// latency, debounce, effect wait, timeout fallback, overrun and mid-operation
// reset, followed by randomized traffic compared against a transaction-level
// reference model (a one-deep hold queue plus an "awaiting effect" flag).
// -----------------------------------------------------------------------------
module tb_audio_path_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_btn;
    logic        data_ready;
    logic [15:0] original_audio;
    logic [15:0] modified_audio;
    logic        process_status;
    logic        dac_busy;
    logic [15:0] dac_sample;
    logic        dac_start;
    logic        mode_active;
    logic        eff_timeout;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_errors = 0;

    audio_path_ctrl #(
        .clock_max   (1000),
        .DEBOUNCE_MS (8),
        .EFF_TIMEOUT (TO)
    ) dut (
        .clk_25mhz      (clk),
        .reset          (reset),
        .mode_btn       (mode_btn),
        .data_ready     (data_ready),
        .original_audio (original_audio),
        .modified_audio (modified_audio),
        .process_status (process_status),
        .dac_busy       (dac_busy),
        .dac_sample     (dac_sample),
        .dac_start      (dac_start),
        .mode_active    (mode_active),
        .eff_timeout    (eff_timeout),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] hold[$];      // sample owned by the controller (0 or 1 entry)
    bit          m_need_eff;   // held sample still waiting for the effect stage
    int          m_waited;
    logic [15:0] m_sample;
    bit          m_start;
    bit          m_mode;
    bit          m_timeout;
    int          m_drops;
    bit          model_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit free;
        if (reset) begin
            hold.delete();
            m_need_eff = 0;
            m_waited   = 0;
            m_sample   = '0;
            m_start    = 0;
            m_mode     = 0;
            m_timeout  = 0;
            m_drops    = 0;
            return;
        end
        free    = (hold.size() == 0);
        m_start = 0;
        if (!free && data_ready) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        if (free) begin
            if (data_ready) begin
                hold.push_back(original_audio);
                m_need_eff = m_mode;
                m_waited   = 0;
            end
        end else if (m_need_eff) begin
            if (process_status) begin
                hold[0]    = modified_audio;
                m_need_eff = 0;
            end else if (m_waited == TO - 1) begin
                m_timeout  = 1;     // held entry is still the original sample
                m_need_eff = 0;
            end else begin
                m_waited++;
            end
        end else if (!dac_busy) begin
            m_sample = hold.pop_front();
            m_start  = 1;
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later,
    // next inputs driven from the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (model_on) begin
            check("rnd_start",   dac_start,   m_start);
            check("rnd_sample",  dac_sample,  m_sample);
            check("rnd_drops",   drop_count,  m_drops);
            check("rnd_timeout", eff_timeout, m_timeout);
            check("rnd_mode",    mode_active, m_mode);
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset          = 1'b0;
        mode_btn       = 1'b0;
        data_ready     = 1'b0;
        process_status = 1'b0;
        dac_busy       = 1'b0;
        original_audio = '0;
        modified_audio = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"},   dac_start,   1'b0);
        check({tag, "_sample"},  dac_sample,  16'h0);
        check({tag, "_mode"},    mode_active, 1'b0);
        check({tag, "_timeout"}, eff_timeout, 1'b0);
        check({tag, "_drops"},   drop_count,  8'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_state("rst");
    endtask

    // Full press/release with no traffic; toggles the mode once.
    task automatic press();
        mode_btn = 1'b1;
        repeat (20) cycle();
        mode_btn = 1'b0;
        repeat (20) cycle();
        m_mode = ~m_mode;
        check("press_mode", mode_active, m_mode);
    endtask

    task automatic rand_phase(input int n, input int ps_div);
        repeat (n) begin
            data_ready     = ($urandom_range(0, 3) == 0);
            original_audio = 16'($urandom);
            modified_audio = 16'($urandom);
            process_status = ($urandom_range(0, ps_div - 1) == 0);
            dac_busy       = ($urandom_range(0, 2) == 0);
            cycle();
        end
        set_idle();
    endtask

    int starts;
    int first_at;
    int to_at;
    int toggles;
    int rise_at;
    logic prev_mode;
    logic [15:0] seen;

    initial begin
        set_idle();
        @(negedge clk);
        do_reset();

        // ---- mode 0 latency ----
        data_ready = 1'b1; original_audio = 16'h1234;
        cycle();
        data_ready = 1'b0; original_audio = 16'h0;
        check("t1_start_k1", dac_start, 1'b0);
        cycle();
        check("t1_start_k2", dac_start, 1'b1);
        check("t1_sample",   dac_sample, 16'h1234);
        check("t1_drops",    drop_count, 8'h0);
        cycle();
        check("t1_start_k3", dac_start, 1'b0);
        check("t1_hold",     dac_sample, 16'h1234);

        // ---- debounce ----
        do_reset();
        mode_btn = 1'b1;
        repeat (5) cycle();
        mode_btn = 1'b0;
        repeat (20) cycle();
        check("t2_glitch_mode", mode_active, 1'b0);
        mode_btn = 1'b1; toggles = 0; rise_at = -1; prev_mode = mode_active;
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) mode_btn = 1'b0;
            cycle();
            if (mode_active !== prev_mode) begin
                toggles++;
                if (rise_at < 0) rise_at = i;
            end
            prev_mode = mode_active;
        end
        m_mode = 1;
        check("t2_mode",    mode_active, 1'b1);
        check("t2_toggles", toggles, 1);
        check("t2_rise_at", rise_at, 11);

        // ---- mode 1 with effect completion ----
        data_ready = 1'b1; original_audio = 16'h0100;
        cycle();
        data_ready = 1'b0; original_audio = 16'h0;
        repeat (9) cycle();
        process_status = 1'b1; modified_audio = 16'h0080;
        cycle();
        process_status = 1'b0; modified_audio = 16'h0;
        check("t3_start_m1", dac_start, 1'b0);
        cycle();
        check("t3_start_m2", dac_start, 1'b1);
        check("t3_sample",   dac_sample, 16'h0080);
        check("t3_timeout",  eff_timeout, 1'b0);
        cycle();
        check("t3_start_m3", dac_start, 1'b0);

        // ---- effect timeout fallback ----
        data_ready = 1'b1; original_audio = 16'hABCD; modified_audio = 16'hDEAD;
        cycle();
        data_ready = 1'b0; original_audio = 16'h0;
        starts = 0; first_at = -1; to_at = -1;
        for (int i = 2; i <= 40; i++) begin
            cycle();
            if (dac_start) begin
                starts++;
                if (first_at < 0) first_at = i;
            end
            if (eff_timeout && to_at < 0) to_at = i;
        end
        modified_audio = 16'h0;
        check("t4_timeout_at", to_at, 17);
        check("t4_start_at",   first_at, 18);
        check("t4_starts",     starts, 1);
        check("t4_sample",     dac_sample, 16'hABCD);
        check("t4_timeout",    eff_timeout, 1'b1);

        // ---- overrun while DAC busy ----
        do_reset();
        dac_busy = 1'b1; data_ready = 1'b1; original_audio = 16'h1111;
        cycle();
        starts = 0;
        for (int i = 1; i <= 30; i++) begin
            data_ready     = (i == 5 || i == 12 || i == 20);
            original_audio = data_ready ? 16'($urandom) : 16'h0;
            cycle();
            if (dac_start) starts++;
        end
        data_ready = 1'b0;
        check("t5_drops",       drop_count, 8'd3);
        check("t5_busy_starts", starts, 0);
        dac_busy = 1'b0; starts = 0; seen = '0;
        repeat (10) begin
            cycle();
            if (dac_start) begin
                starts++;
                seen = dac_sample;
            end
        end
        check("t5_starts", starts, 1);
        check("t5_sample", seen, 16'h1111);
        dac_busy = 1'b1; data_ready = 1'b1; original_audio = 16'h2222;
        repeat (301) cycle();
        data_ready = 1'b0;
        check("t5_saturate", drop_count, 8'd255);
        dac_busy = 1'b0;
        repeat (3) cycle();
        check("t5_sat_hold", drop_count, 8'd255);

        // ---- reset while waiting for the effect ----
        do_reset();
        press();
        data_ready = 1'b1; original_audio = 16'h5555;
        cycle();
        data_ready = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_state("t6");
        process_status = 1'b1; modified_audio = 16'h7777; starts = 0;
        repeat (10) begin
            cycle();
            if (dac_start) starts++;
        end
        set_idle();
        check("t6_starts", starts, 0);
        check("t6_sample", dac_sample, 16'h0);

        // ---- randomized traffic against the model ----
        do_reset();
        model_on = 1'b1;
        rand_phase(400, 4);
        repeat (25) cycle();
        model_on = 1'b0;
        press();
        model_on = 1'b1;
        rand_phase(600, 24);
        repeat (25) cycle();
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
